// File: rtl/scope_capture.sv
// Triggered waveform capture with a circular pre/post-trigger buffer.
// Arm, fill pre-trigger window, wait for a hysteresis edge, fill post window, read out.
module scope_capture #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] smp_in,
  input  logic                     smp_valid,
  input  logic                     arm,
  input  logic signed [DATA_W-1:0] trig_level,
  input  logic        [3:0]        trig_hyst,
  input  logic        [ADDR_W-1:0] pre_cnt,
  input  logic                     rd_en,
  output logic        [DATA_W-1:0] rd_data,
  output logic                     rd_valid,
  output logic                     triggered,
  output logic                     done,
  output logic        [2:0]        state
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   C_ONE = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                    r_state;
  logic signed [DATA_W-1:0]  r_level;
  logic        [3:0]         r_hyst;
  logic        [ADDR_W-1:0]  r_pre;
  logic        [ADDR_W-1:0]  r_wr_ptr;
  logic        [ADDR_W-1:0]  r_fill_cnt;
  logic        [ADDR_W-1:0]  r_post_cnt;
  logic        [ADDR_W-1:0]  r_trig_ptr;
  logic        [ADDR_W-1:0]  r_rd_ptr;
  logic        [ADDR_W:0]    r_rd_cnt;
  logic                      r_below;
  logic                      r_trig;
  logic                      r_done;
  logic                      r_rd_valid;
  logic        [DATA_W-1:0]  r_rd_data;
  logic        [DATA_W-1:0]  r_mem [DEPTH];

  logic                      w_capturing;
  logic                      w_we;
  logic signed [DATA_W:0]    w_smp_x;
  logic signed [DATA_W:0]    w_lvl_x;
  logic signed [DATA_W:0]    w_hyst_x;
  logic signed [DATA_W:0]    w_thr;
  logic                      w_is_below;
  logic                      w_at_level;
  logic                      w_fire;
  logic        [ADDR_W-1:0]  w_post_len;
  logic        [ADDR_W-1:0]  w_fill_nx;
  logic                      w_arm_ok;
  logic                      w_rd_ok;

  // Threshold math is one bit wider so level minus hysteresis never wraps
  assign w_smp_x  = {smp_in[DATA_W-1], smp_in};
  assign w_lvl_x  = {r_level[DATA_W-1], r_level};
  assign w_hyst_x = {{(DATA_W-3){1'b0}}, r_hyst};
  assign w_thr    = w_lvl_x - w_hyst_x;

  assign w_is_below = w_smp_x < w_thr;
  assign w_at_level = w_smp_x >= w_lvl_x;

  assign w_capturing = (r_state == S_FILL) ||
                       (r_state == S_ARMED) ||
                       (r_state == S_POST);
  assign w_we        = smp_valid && w_capturing;

  assign w_fire = (r_state == S_ARMED) && smp_valid &&
                  r_below && w_at_level;

  assign w_post_len = A_MAX - r_pre;
  assign w_fill_nx  = r_fill_cnt + A_ONE;

  assign w_arm_ok = arm &&
                    ((r_state == S_IDLE) || (r_state == S_DONE));

  // Arm wins over a read; reads stop once the whole buffer was returned
  assign w_rd_ok = rd_en && !arm && (r_state == S_DONE) &&
                   !r_rd_cnt[ADDR_W];

  // Sample storage, no reset needed for buffer contents
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wr_ptr] <= smp_in;
  end

  // Capture FSM with registered status and readout outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_level    <= '0;
      r_hyst     <= '0;
      r_pre      <= '0;
      r_wr_ptr   <= '0;
      r_fill_cnt <= '0;
      r_post_cnt <= '0;
      r_trig_ptr <= '0;
      r_rd_ptr   <= '0;
      r_rd_cnt   <= '0;
      r_below    <= 1'b0;
      r_trig     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_trig     <= 1'b0;
      r_rd_valid <= 1'b0;
      if (w_we) r_wr_ptr <= r_wr_ptr + A_ONE;
      if (w_we && w_is_below && (r_state != S_POST))
        r_below <= 1'b1;
      if (w_arm_ok) begin
        r_level    <= trig_level;
        r_hyst     <= trig_hyst;
        r_pre      <= pre_cnt;
        r_wr_ptr   <= '0;
        r_fill_cnt <= '0;
        r_rd_cnt   <= '0;
        r_below    <= 1'b0;
        r_done     <= 1'b0;
        r_state    <= (pre_cnt == '0) ? S_ARMED : S_FILL;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            r_state <= S_IDLE;
          end
          S_FILL: begin
            if (smp_valid) begin
              r_fill_cnt <= w_fill_nx;
              if (w_fill_nx == r_pre) r_state <= S_ARMED;
            end
          end
          S_ARMED: begin
            if (w_fire) begin
              r_trig     <= 1'b1;
              r_trig_ptr <= r_wr_ptr;
              r_post_cnt <= w_post_len;
              if (w_post_len == '0) begin
                r_state  <= S_DONE;
                r_done   <= 1'b1;
                r_rd_ptr <= r_wr_ptr - r_pre;
              end else begin
                r_state  <= S_POST;
              end
            end
          end
          S_POST: begin
            if (smp_valid) begin
              r_post_cnt <= r_post_cnt - A_ONE;
              if (r_post_cnt == A_ONE) begin
                r_state  <= S_DONE;
                r_done   <= 1'b1;
                r_rd_ptr <= r_trig_ptr - r_pre;
              end
            end
          end
          S_DONE: begin
            if (w_rd_ok) begin
              r_rd_data  <= r_mem[r_rd_ptr];
              r_rd_valid <= 1'b1;
              r_rd_ptr   <= r_rd_ptr + A_ONE;
              r_rd_cnt   <= r_rd_cnt + C_ONE;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign triggered = r_trig;
  assign done      = r_done;
  assign state     = r_state;

endmodule

// File: tb/tb_scope_capture.sv
// Bench for scope_capture: table-driven ramps, hand corner sequences,
// and random streams checked against a stream-level reference model.
module tb_scope_capture;

  localparam int NSTIM = 1024;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] smp_in = '0;
  logic       smp_valid = 1'b0;
  logic       arm = 1'b0;
  logic [7:0] trig_level = '0;
  logic [3:0] trig_hyst = '0;
  logic [7:0] pre_cnt = '0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       triggered;
  logic       done;
  logic [2:0] state;

  int n_chk = 0;
  int n_fail = 0;
  int stim [NSTIM];

  typedef struct {
    int start;
    int lvl;
    int hy;
    int pre;
    int gap;
    int t_idx;
    int t_first;
    int t_last;
  } vec_t;

  vec_t tab [8];

  scope_capture #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .smp_in    (smp_in),
    .smp_valid (smp_valid),
    .arm       (arm),
    .trig_level(trig_level),
    .trig_hyst (trig_hyst),
    .pre_cnt   (pre_cnt),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .triggered (triggered),
    .done      (done),
    .state     (state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int s8(input int v);
    return ((v + 128) % 256 + 256) % 256 - 128;
  endfunction

  // Index of the trigger sample in the post-arm valid stream, or -1.
  // Rule: index >= pre, value >= level, and some earlier sample < level-hyst.
  function automatic int model_trig(input int lvl, input int hy,
                                    input int pre);
    bit seen_low = 0;
    for (int i = 0; i < NSTIM; i++) begin
      if (i >= pre && seen_low && stim[i] >= lvl) return i;
      if (stim[i] < lvl - hy) seen_low = 1;
    end
    return -1;
  endfunction

  task automatic do_arm(input int lvl, input int hy, input int pre);
    trig_level = 8'(lvl);
    trig_hyst  = 4'(hy);
    pre_cnt    = 8'(pre);
    smp_valid  = 1'b0;
    arm        = 1'b1;
    tick();
    arm        = 1'b0;
    chk("arm_state", int'(state), (pre == 0) ? 2 : 1);
  endtask

  task automatic run_capture(input int lvl, input int hy, input int pre,
                             input int gap, input bit use_tab,
                             input int t_idx, input int t_first,
                             input int t_last);
    int m_trig, exp_trig, idx, cons, trig_at, done_at, npulse, v, rv;
    m_trig   = model_trig(lvl, hy, pre);
    exp_trig = use_tab ? t_idx : m_trig;
    idx = 0; trig_at = -1; done_at = -1; npulse = 0;
    do_arm(lvl, hy, pre);
    for (int cyc = 0; cyc < 3000 && idx < NSTIM; cyc++) begin
      case (gap)
        0:       v = 1;
        1:       v = (cyc % 2 == 0) ? 1 : 0;
        default: v = int'($urandom_range(0, 1));
      endcase
      smp_valid = v[0];
      smp_in    = 8'(stim[idx]);
      tick();
      cons = v ? idx : -2;
      if (v != 0) idx++;
      if (triggered) begin
        npulse++;
        if (trig_at == -1) trig_at = cons;
      end
      if (done) begin
        done_at = cons;
        break;
      end
    end
    smp_valid = 1'b0;
    chk("trig_idx", trig_at, exp_trig);
    if (exp_trig < 0) begin
      chk("notrig_done", done_at, -1);
      chk("notrig_state", int'(state), 2);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      return;
    end
    chk("trig_pulses", npulse, 1);
    chk("done_idx", done_at, exp_trig + 255 - pre);
    chk("done_state", int'(state), 4);
    for (int k = 0; k < 256; k++) begin
      rd_en = 1'b1;
      tick();
      rv = int'($signed(rd_data));
      chk($sformatf("read%0d_valid", k), int'(rd_valid), 1);
      chk($sformatf("read%0d", k), rv, stim[m_trig - pre + k]);
      if (use_tab && k == 0)   chk("first_read", rv, t_first);
      if (use_tab && k == 255) chk("last_read", rv, t_last);
    end
    tick();
    chk("read257_valid", int'(rd_valid), 0);
    rd_en = 1'b0;
    tick();
    chk("idle_rd_valid", int'(rd_valid), 0);
    chk("done_held", int'(done), 1);
  endtask

  initial begin
    int tcnt, rcnt;
    tab[0] = '{0,   0,   4,  16,  0, 256, -16, -17};
    tab[1] = '{0,   0,   4,  0,   0, 256, 0,   -1};
    tab[2] = '{1,   0,   4,  255, 0, 255, 1,   0};
    tab[3] = '{0,   0,   4,  16,  1, 256, -16, -17};
    tab[4] = '{50,  20,  0,  100, 0, 226, -80, -81};
    tab[5] = '{-30, -10, 15, 2,   0, 20,  -12, -13};
    tab[6] = '{-25, -10, 15, 0,   0, 271, -10, -11};
    tab[7] = '{0,  -128, 15, 0,   0, -1,  0,   0};

    // Reset state
    tick();
    tick();
    chk("rst_state", int'(state), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_trig", int'(triggered), 0);
    chk("rst_rdv", int'(rd_valid), 0);
    chk("rst_rdd", int'(rd_data), 0);
    rst_n = 1'b1;
    tick();

    // Hysteresis: +-3 around level 0 never arms the edge; -5 then 0 fires.
    // Arm and rd_en are pulsed mid-way and must be ignored.
    do_arm(0, 4, 0);
    tcnt = 0; rcnt = 0;
    rd_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      smp_valid = 1'b1;
      smp_in = (i % 2 != 0) ? 8'sd3 : -8'sd3;
      if (i == 20) begin
        arm = 1'b1;
        pre_cnt = 8'd5;
      end
      tick();
      arm = 1'b0;
      if (triggered) tcnt++;
      if (rd_valid) rcnt++;
    end
    rd_en = 1'b0;
    chk("alt_trig", tcnt, 0);
    chk("alt_rdv", rcnt, 0);
    chk("alt_state", int'(state), 2);
    smp_in = -8'sd5;
    tick();
    chk("m5_trig", int'(triggered), 0);
    smp_in = 8'sd0;
    tick();
    chk("zero_trig", int'(triggered), 1);
    smp_valid = 1'b0;
    tick();
    chk("trig_once", int'(triggered), 0);
    chk("post_state", int'(state), 3);

    // Asynchronous reset in POST
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state", int'(state), 0);
    chk("arst_trig", int'(triggered), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_rdv", int'(rd_valid), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table-driven ramps
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < NSTIM; i++) stim[i] = s8(tab[t].start + i);
      run_capture(tab[t].lvl, tab[t].hy, tab[t].pre, tab[t].gap, 1'b1,
                  tab[t].t_idx, tab[t].t_first, tab[t].t_last);
    end

    // Random streams vs reference model
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NSTIM; i++)
        stim[i] = int'($urandom_range(0, 255)) - 128;
      run_capture(int'($urandom_range(0, 40)) - 20,
                  int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 255)),
                  2, 1'b0, 0, 0, 0);
    end

    // Arm beats rd_en in DONE, then reset clears held readout data
    trig_level = 8'd0;
    trig_hyst  = 4'd4;
    pre_cnt    = 8'd16;
    arm   = 1'b1;
    rd_en = 1'b1;
    tick();
    arm   = 1'b0;
    rd_en = 1'b0;
    chk("prio_rdv", int'(rd_valid), 0);
    chk("prio_state", int'(state), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst2_state", int'(state), 0);
    chk("arst2_rdd", int'(rd_data), 0);
    tick();
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
